// File: rtl/cfg_bank_pkg.sv
// Shared types and sizing helpers for the configuration-bank loader.
package cfg_bank_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } cfg_state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : cfg_bank_pkg

// File: rtl/cfg_bank_loader.sv
// Streams a bitstream into one bitline/wordline configuration bank, one row at a time:
// assemble the row on the bitlines, pulse its wordline, idle one cycle, move on.
module cfg_bank_loader
  import cfg_bank_pkg::*;
#(
  parameter int NUM_BL   = 8,
  parameter int NUM_WL   = 8,
  parameter int DATA_W   = 8,
  parameter int WL_PULSE = 2
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              bs_valid,
  input  logic [DATA_W-1:0] bs_data,
  output logic              bs_ready,
  output logic [NUM_BL-1:0] bl,
  output logic [NUM_WL-1:0] wl,
  output logic              busy,
  output logic              done
);

  localparam int WORDS   = NUM_BL / DATA_W;
  localparam int ROW_W   = cnt_width(NUM_WL);
  localparam int WORD_W  = cnt_width(WORDS);
  localparam int PULSE_W = cnt_width(WL_PULSE + 1);

  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(NUM_WL - 1);
  localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(WORDS - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(WL_PULSE - 1);

  cfg_state_e          state_q, state_d;
  logic [ROW_W-1:0]    row_q,   row_d;
  logic [WORD_W-1:0]   word_q,  word_d;
  logic [PULSE_W-1:0]  pulse_q, pulse_d;
  logic [NUM_BL-1:0]   bl_q,    bl_d;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    word_d  = word_q;
    pulse_d = pulse_q;
    bl_d    = bl_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD;
            row_d   = '0;
            word_d  = '0;
          end
        end
        LOAD: begin
          if (bs_valid) begin
            bl_d[word_q*DATA_W +: DATA_W] = bs_data;
            // Terminal compare first so the word counter never wraps.
            if (word_q == WORD_LAST) begin
              state_d = WRITE;
              pulse_d = '0;
            end else begin
              word_d = word_q + 1'b1;
            end
          end
        end
        WRITE: begin
          if (pulse_q == PULSE_LAST) begin
            state_d = HOLD;
          end else begin
            pulse_d = pulse_q + 1'b1;
          end
        end
        HOLD: begin
          if (row_q == ROW_LAST) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
            row_d   = row_q + 1'b1;
            word_d  = '0;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      word_q  <= '0;
      pulse_q <= '0;
      // NOTE: the bitline register is reset explicitly; it is a plain register, not a memory array.
      bl_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      word_q  <= word_d;
      pulse_q <= pulse_d;
      bl_q    <= bl_d;
    end
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  always_comb begin
    wl = '0;
    if (state_q == WRITE) begin
      wl[row_q] = 1'b1;
    end
  end

  assign bl       = bl_q;
  assign bs_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule : cfg_bank_loader

// File: tb/tb_cfg_bank_loader.sv
// Self-checking bench for cfg_bank_loader: a timeline model built from the row/word/pulse
// rules predicts every cycle of a load for the default bank; a 16x2 bank is checked directly.
module tb_cfg_bank_loader;

  localparam int BL   = 8;
  localparam int WLN  = 8;
  localparam int DW   = 8;
  localparam int PL   = 2;
  localparam int WPR  = BL / DW;
  localparam int MAXC = 512;

  logic          prog_clk = 1'b0;
  logic          prog_rst_n = 1'b0;
  logic          start, abort, bs_valid;
  logic [DW-1:0] bs_data;
  logic          bs_ready, busy, done;
  logic [BL-1:0] bl;
  logic [WLN-1:0] wl;

  logic          w_start, w_abort, w_bs_valid;
  logic [7:0]    w_bs_data;
  logic          w_bs_ready, w_busy, w_done;
  logic [15:0]   w_bl;
  logic [1:0]    w_wl;

  int total = 0;
  int bad   = 0;

  cfg_bank_loader #(.NUM_BL(BL), .NUM_WL(WLN), .DATA_W(DW), .WL_PULSE(PL)) dut (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start), .abort(abort),
    .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready), .bl(bl), .wl(wl),
    .busy(busy), .done(done)
  );

  cfg_bank_loader #(.NUM_BL(16), .NUM_WL(2), .DATA_W(8), .WL_PULSE(2)) dut_w (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(w_start), .abort(w_abort),
    .bs_valid(w_bs_valid), .bs_data(w_bs_data), .bs_ready(w_bs_ready), .bl(w_bl), .wl(w_wl),
    .busy(w_busy), .done(w_done)
  );

  always #5 prog_clk = ~prog_clk;

  // Reference model: the bitstream, per-word stall counts, and the predicted timeline.
  logic [DW-1:0]  words     [WLN*WPR];
  int             stall     [WLN*WPR];
  logic [BL-1:0]  exp_row   [WLN];
  int             row_start [WLN];
  logic [WLN-1:0] exp_wl    [MAXC];
  logic           exp_ready [MAXC];
  logic           exp_done  [MAXC];
  int             exp_blr   [MAXC];
  logic           drv_valid [MAXC];
  logic [DW-1:0]  drv_data  [MAXC];
  int             tl_len;

  task automatic build_timeline();
    int c = 0;
    for (int r = 0; r < WLN; r++) begin
      row_start[r] = c;
      exp_row[r]   = '0;
      for (int w = 0; w < WPR; w++) begin
        int idx = r * WPR + w;
        for (int s = 0; s < stall[idx]; s++) begin
          exp_wl[c] = '0; exp_ready[c] = 1'b1; exp_done[c] = 1'b0; exp_blr[c] = -1;
          drv_valid[c] = 1'b0; drv_data[c] = DW'($urandom); c++;
        end
        exp_wl[c] = '0; exp_ready[c] = 1'b1; exp_done[c] = 1'b0; exp_blr[c] = -1;
        drv_valid[c] = 1'b1; drv_data[c] = words[idx];
        exp_row[r][w*DW +: DW] = words[idx];
        c++;
      end
      // Wordline pulse then hold: the bank must ignore whatever the stream presents here.
      for (int p = 0; p < PL + 1; p++) begin
        exp_wl[c] = (p < PL) ? (WLN'(1) << r) : '0;
        exp_ready[c] = 1'b0; exp_done[c] = 1'b0; exp_blr[c] = r;
        drv_valid[c] = 1'($urandom); drv_data[c] = DW'($urandom); c++;
      end
    end
    exp_wl[c] = '0; exp_ready[c] = 1'b0; exp_done[c] = 1'b1; exp_blr[c] = WLN - 1;
    drv_valid[c] = 1'($urandom); drv_data[c] = DW'($urandom); c++;
    tl_len = c;
  endtask

  task automatic randomize_load(input int max_stall);
    for (int i = 0; i < WLN * WPR; i++) begin
      words[i] = DW'($urandom);
      stall[i] = (max_stall > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, max_stall)) : 0;
    end
  endtask

  // Runs one load against the timeline; optionally aborts, resets, or pulses start at a cycle.
  task automatic run_load(input string tag, input int abort_at, input int rst_at, input int start_at);
    build_timeline();
    @(negedge prog_clk) start = 1'b1;
    @(negedge prog_clk) start = 1'b0;
    for (int c = 0; c < tl_len; c++) begin
      total++;
      if (wl !== exp_wl[c]) begin
        bad++; $display("FAIL %s wl c=%0d got=%h want=%h", tag, c, wl, exp_wl[c]);
      end
      total++;
      if (bs_ready !== exp_ready[c] || done !== exp_done[c] || busy !== 1'b1) begin
        bad++; $display("FAIL %s ctl c=%0d got rdy=%b done=%b busy=%b want rdy=%b done=%b busy=1",
                        tag, c, bs_ready, done, busy, exp_ready[c], exp_done[c]);
      end
      if (exp_blr[c] >= 0) begin
        total++;
        if (bl !== exp_row[exp_blr[c]]) begin
          bad++; $display("FAIL %s bl c=%0d got=%h want=%h", tag, c, bl, exp_row[exp_blr[c]]);
        end
      end
      if (c == abort_at) begin
        bs_valid = 1'b1; abort = 1'b1;
        @(negedge prog_clk) abort = 1'b0; bs_valid = 1'b0;
        total++;
        if (wl !== '0 || busy !== 1'b0 || done !== 1'b0 || bl !== exp_row[exp_blr[c]]) begin
          bad++; $display("FAIL %s abort got wl=%h busy=%b done=%b bl=%h want 0/0/0/%h",
                          tag, wl, busy, done, bl, exp_row[exp_blr[c]]);
        end
        for (int k = 0; k < 4; k++) begin
          @(negedge prog_clk);
          total++;
          if (done !== 1'b0 || wl !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s post_abort k=%0d got done=%b wl=%h busy=%b", tag, k, done, wl, busy);
          end
        end
        return;
      end
      if (c == rst_at) begin
        bs_valid = 1'b0;
        #2 prog_rst_n = 1'b0;
        #1;
        total++;
        if (bl !== '0 || wl !== '0 || bs_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
          bad++; $display("FAIL %s async_rst got bl=%h wl=%h rdy=%b busy=%b done=%b want all 0",
                          tag, bl, wl, bs_ready, busy, done);
        end
        @(negedge prog_clk) #1 prog_rst_n = 1'b1;
        repeat (2) @(negedge prog_clk);
        total++;
        if (busy !== 1'b0 || bl !== '0) begin
          bad++; $display("FAIL %s after_rst got busy=%b bl=%h want 0/0", tag, busy, bl);
        end
        return;
      end
      bs_valid = drv_valid[c];
      bs_data  = drv_data[c];
      start    = (c == start_at);
      @(negedge prog_clk);
    end
    bs_valid = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || wl !== '0 || bl !== exp_row[WLN-1]) begin
      bad++; $display("FAIL %s idle_after got busy=%b done=%b wl=%h bl=%h want 0/0/0/%h",
                      tag, busy, done, wl, bl, exp_row[WLN-1]);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (bl !== '0 || wl !== '0 || bs_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset got bl=%h wl=%h rdy=%b busy=%b done=%b want all 0", bl, wl, bs_ready, busy, done);
    end
    total++;
    if (w_bl !== '0 || w_wl !== '0 || w_bs_ready !== 1'b0 || w_busy !== 1'b0 || w_done !== 1'b0) begin
      bad++; $display("FAIL reset_wide got bl=%h wl=%h rdy=%b busy=%b done=%b want all 0",
                      w_bl, w_wl, w_bs_ready, w_busy, w_done);
    end
    #9 prog_rst_n = 1'b1;
    repeat (2) @(negedge prog_clk);
  endtask

  task automatic test_walk();
    for (int i = 0; i < WLN * WPR; i++) begin
      words[i] = DW'(i + 1);
      stall[i] = 0;
    end
    run_load("walk", -1, -1, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      randomize_load(3);
      run_load("random", -1, -1, -1);
    end
  endtask

  task automatic test_stall();
    randomize_load(0);
    stall[3] = 5;
    run_load("stall", -1, -1, -1);
  endtask

  task automatic test_abort();
    randomize_load(2);
    build_timeline();
    run_load("abort", row_start[3] + WPR, -1, -1);
    randomize_load(1);
    run_load("restart", -1, -1, -1);
  endtask

  task automatic test_start_ignored();
    randomize_load(1);
    build_timeline();
    run_load("start_busy", -1, -1, row_start[2] + 1);
    @(negedge prog_clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge prog_clk) begin start = 1'b0; abort = 1'b0; end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (busy !== 1'b0 || bs_ready !== 1'b0) begin
        bad++; $display("FAIL start_abort k=%0d got busy=%b rdy=%b want 0/0", k, busy, bs_ready);
      end
      @(negedge prog_clk);
    end
  endtask

  task automatic test_reset_midload();
    randomize_load(0);
    build_timeline();
    run_load("rst_mid", -1, row_start[2], -1);
  endtask

  // 16-bit rows, two words each: R = 2 + 2 + 1 = 5, done at cycle 10 after start.
  task automatic test_wide();
    logic [7:0]  feed  [12] = '{8'h34, 8'h12, 8'hEE, 8'hEE, 8'hEE, 8'h78, 8'h56,
                                8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE};
    logic [1:0]  ewl   [12] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00,
                                2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [15:0] ebl   [12] = '{16'h0, 16'h0, 16'h1234, 16'h1234, 16'h1234, 16'h0, 16'h0,
                                16'h5678, 16'h5678, 16'h5678, 16'h5678, 16'h5678};
    @(negedge prog_clk) w_start = 1'b1;
    @(negedge prog_clk) w_start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      total++;
      if (w_wl !== ewl[c]) begin
        bad++; $display("FAIL wide wl c=%0d got=%b want=%b", c, w_wl, ewl[c]);
      end
      if (ebl[c] != 16'h0) begin
        total++;
        if (w_bl !== ebl[c]) begin
          bad++; $display("FAIL wide bl c=%0d got=%h want=%h", c, w_bl, ebl[c]);
        end
      end
      total++;
      if (w_done !== (c == 10) || w_busy !== (c <= 10)) begin
        bad++; $display("FAIL wide ctl c=%0d got done=%b busy=%b want done=%b busy=%b",
                        c, w_done, w_busy, (c == 10), (c <= 10));
      end
      w_bs_valid = 1'b1;
      w_bs_data  = feed[c];
      @(negedge prog_clk);
    end
    w_bs_valid = 1'b0;
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; bs_valid = 1'b0; bs_data = '0;
    w_start = 1'b0; w_abort = 1'b0; w_bs_valid = 1'b0; w_bs_data = '0;
    test_reset();
    test_walk();
    test_random();
    test_stall();
    test_abort();
    test_start_ignored();
    test_reset_midload();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cfg_bank_loader

// File: doc/cfg_bank_loader.md
# cfg_bank_loader

Configuration-memory bank loader for one tile memory bank (grid IO or connection block). Accepts a streamed bitstream over a valid/ready handshake and writes it row by row into the bank's bitline/wordline configuration memory. It assembles one full bitline row, pulses the matching wordline for a fixed number of cycles, then moves to the next row. A tile instantiates one loader per bank: for example, 8×8 for the IO grid and 72×72 for the connection block.

## Interface
Parameters:
- `NUM_BL`, 8: bitlines per row; must be a multiple of `DATA_W`.
- `NUM_WL`, 8: wordlines (rows) in the bank.
- `DATA_W`, 8: bitstream word width.
- `WL_PULSE`, 2: cycles each wordline is held high; must be ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `prog_clk`  in  1  programming clock.
- `prog_rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a bank load; sampled only in IDLE.
- `abort`  in  1  cancel the load; highest priority.
- `bs_valid`  in  1  bitstream word valid.
- `bs_data`  in  DATA_W  bitstream word.
- `bs_ready`  out  1  loader accepts a word this cycle.
- `bl`  out  NUM_BL  bitline drive.
- `wl`  out  NUM_WL  wordline drive; one-hot or zero.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the last row has completed.

## Operation
States and transitions:
- IDLE: `start` → LOAD with row=0, word=0.
- LOAD: `bs_ready`=1. On each accepted word (`bs_valid & bs_ready`), `bs_data` is written into `bl[word*DATA_W +: DATA_W]` and word increments. When the last word of the row (word = NUM_BL/DATA_W−1) is accepted → WRITE.
- WRITE: `wl[row]`=1 for exactly `WL_PULSE` cycles; `bl` is stable → HOLD.
- HOLD: one cycle with `wl`=0 and `bl` held. If row = NUM_WL−1 → DONE; otherwise row+1 and word=0 → LOAD.
- DONE: `done`=1 for one cycle → IDLE.

Rules:
- Row order is wl[0] first; word order is LSB slice first.
- `bs_ready` is high only in LOAD. There is no skid buffer; a stalled `bs_valid` simply holds the loader in LOAD indefinitely.
- `bl` may change during LOAD only; `wl` is all-zero in LOAD, HOLD, DONE and IDLE.
- `bl` retains its last row after DONE; it is cleared only by reset.
- `abort`, in any state, forces IDLE on the next edge. `wl` is 0 from that edge, `done` is not pulsed, and `bl` is held.
- `start` while busy is ignored. `start` together with `abort` in IDLE: abort wins and the loader stays in IDLE.
- Counter widths are $clog2 of (NUM_WL) and of (NUM_BL/DATA_W), with a minimum of 1 bit. Counters never wrap: the terminal compare precedes the increment.

Reset values (`prog_rst_n`=0, asynchronous): state=IDLE, `bl`=0, `wl`=0, `bs_ready`=0, `busy`=0, `done`=0, counters=0.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- With `start` sampled at edge t0 and `bs_valid` held high: LOAD begins at t1, and row k occupies cycles t1 + k·R through t1 + k·R + R−1, where R = NUM_BL/DATA_W + WL_PULSE + 1.
- `done` is high in cycle t1 + NUM_WL·R. For the defaults, R=4 and `done` is high at t33.
- `wl[row]` rises the cycle after the last word of that row is accepted.
- Reset deassertion mid-load: the loader restarts in IDLE; a partial bank must be reloaded by software.

## Structure
- Package `cfg_bank_pkg` holds:
  - the state enum `cfg_state_e` {IDLE, LOAD, WRITE, HOLD, DONE};
  - a width helper function for counter sizing.
- Single module, no sub-modules. The pulse counter is inline and sized $clog2(WL_PULSE+1).

## Test plan
- Defaults, stream bytes 0x01..0x08 with continuous valid → `wl` walks 0x01..0x80, each high 2 cycles; `bl` equals byte k while `wl[k]`=1; `done` pulses at t33.
- NUM_BL=16, NUM_WL=2, stream 0x34,0x12,0x78,0x56 → `bl`=0x1234 during `wl`=0b01, `bl`=0x5678 during `wl`=0b10.
- Defaults, `bs_valid` low for 5 cycles mid-row → `wl` stays 0 and `bs_ready` stays 1; completion is delayed by exactly 5 cycles.
- `abort` during WRITE of row 3 → `wl`=0 the next cycle, `busy`=0, no `done`; a subsequent `start` restarts at row 0.
- `start` pulsed while busy, and `start`+`abort` together in IDLE → no state change and no restart in either case.
- `prog_rst_n` asserted mid-LOAD, asynchronously between edges → all outputs read 0 immediately, before the next clock edge.
